// File: rtl/param_pkg.sv
// Shared sizing for the AR round-robin arbiter and its queue-side interface.
package param_pkg;

    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned NUM_MASTERS     = 4;
    localparam int unsigned MASTER_ID_WIDTH = id_width(NUM_MASTERS);

    // Packed AR request layout: id|addr|len|size|burst|prot|snoop|domain
    localparam int unsigned AR_ID_WIDTH     = 4;
    localparam int unsigned AR_ADDR_WIDTH   = 32;
    localparam int unsigned AR_LEN_WIDTH    = 8;
    localparam int unsigned AR_SIZE_WIDTH   = 3;
    localparam int unsigned AR_BURST_WIDTH  = 2;
    localparam int unsigned AR_PROT_WIDTH   = 3;
    localparam int unsigned AR_SNOOP_WIDTH  = 4;
    localparam int unsigned AR_DOMAIN_WIDTH = 2;
    localparam int unsigned AR_Q_DATA_WIDTH = AR_ID_WIDTH + AR_ADDR_WIDTH + AR_LEN_WIDTH
                                            + AR_SIZE_WIDTH + AR_BURST_WIDTH + AR_PROT_WIDTH
                                            + AR_SNOOP_WIDTH + AR_DOMAIN_WIDTH;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StHold = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ar_rr_arbiter_if.sv
// Queue-side and downstream signals of the AR arbiter, seen from the arbiter (master).
interface ar_rr_arbiter_if #(
    parameter int unsigned NUM_MASTERS = param_pkg::NUM_MASTERS,
    parameter int unsigned REQ_WIDTH   = param_pkg::AR_Q_DATA_WIDTH
);
    import param_pkg::*;

    localparam int unsigned IdW = id_width(NUM_MASTERS);

    logic [NUM_MASTERS-1:0]           q_empty_i;
    logic [NUM_MASTERS*REQ_WIDTH-1:0] q_data_i;
    logic [NUM_MASTERS-1:0]           q_pop_o;
    logic                             req_valid_o;
    logic                             req_ready_i;
    logic [REQ_WIDTH-1:0]             req_data_o;
    logic [IdW-1:0]                   req_src_o;

    modport master (
        input  q_empty_i, q_data_i, req_ready_i,
        output q_pop_o, req_valid_o, req_data_o, req_src_o
    );

    modport slave (
        output q_empty_i, q_data_i, req_ready_i,
        input  q_pop_o, req_valid_o, req_data_o, req_src_o
    );

endinterface

// File: rtl/rr_pick.sv
// Rotating priority select: first set request at or above ptr_i, wrapping to 0.
module rr_pick #(
    parameter int unsigned NUM_MASTERS = param_pkg::NUM_MASTERS,
    parameter int unsigned IdW         = param_pkg::id_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IdW-1:0]         ptr_i,
    output logic                   grant_valid_o,
    output logic [IdW-1:0]         grant_idx_o
);
    import param_pkg::*;

    function automatic logic [IdW-1:0] wrap_add(input logic [IdW-1:0] p, input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        return IdW'((s >= NUM_MASTERS) ? s - NUM_MASTERS : s);
    endfunction

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        grant_valid_o = 1'b0;
        grant_idx_o   = '0;
        for (int off = NUM_MASTERS - 1; off >= 0; off--) begin
            if (req_i[wrap_add(ptr_i, unsigned'(off))]) begin
                grant_valid_o = 1'b1;
                grant_idx_o   = wrap_add(ptr_i, unsigned'(off));
            end
        end
    end

endmodule

// File: rtl/ar_rr_arbiter.sv
// Round-robin arbiter draining NUM_MASTERS AR queues into one registered request slot.
module ar_rr_arbiter #(
    parameter int unsigned NUM_MASTERS = param_pkg::NUM_MASTERS,
    parameter int unsigned REQ_WIDTH   = param_pkg::AR_Q_DATA_WIDTH
) (
    input logic               clk,
    input logic               resetn,
    ar_rr_arbiter_if.master   bus
);
    import param_pkg::*;

    localparam int unsigned IdW = id_width(NUM_MASTERS);

    arb_state_e           state_q, state_d;
    logic [REQ_WIDTH-1:0] data_q, data_d;
    logic [IdW-1:0]       src_q, src_d;
    logic [IdW-1:0]       ptr_q, ptr_d;
    logic                 pick_valid;
    logic [IdW-1:0]       pick_idx;
    logic                 load_en;
    logic                 grant;

    rr_pick #(
        .NUM_MASTERS(NUM_MASTERS),
        .IdW        (IdW)
    ) u_pick (
        .req_i        (~bus.q_empty_i),
        .ptr_i        (ptr_q),
        .grant_valid_o(pick_valid),
        .grant_idx_o  (pick_idx)
    );

    always_comb begin
        load_en     = (state_q == StIdle) || bus.req_ready_i;
        // Gating with resetn keeps pops quiet while the block is held in reset.
        grant       = resetn && load_en && pick_valid;
        state_d     = state_q;
        data_d      = data_q;
        src_d       = src_q;
        ptr_d       = ptr_q;
        bus.q_pop_o = '0;
        if (grant) begin
            bus.q_pop_o[pick_idx] = 1'b1;
            state_d = StHold;
            data_d  = bus.q_data_i[int'(pick_idx) * REQ_WIDTH +: REQ_WIDTH];
            src_d   = pick_idx;
            ptr_d   = (pick_idx == IdW'(NUM_MASTERS - 1)) ? '0 : pick_idx + IdW'(1);
        end else if ((state_q == StHold) && bus.req_ready_i) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            data_q  <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.req_valid_o = (state_q == StHold);
    assign bus.req_data_o  = data_q;
    assign bus.req_src_o   = src_q;

endmodule

// File: doc/ar_rr_arbiter.md
AR_RR_ARBITER -- requirements
Module: ar_rr_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of per-master AR request queues arbitrated (2..16).
REQ-002 Parameter REQ_WIDTH, default AR_Q_DATA_WIDTH: width of one packed AR request (id|addr|len|size|burst|prot|snoop|domain).
REQ-003 Port clk  input  1  single clock; all state on rising edge.
REQ-004 Port resetn  input  1  reset, synchronous and active-low.
REQ-005 Port q_empty_i  input  NUM_MASTERS  bit i = AR queue i empty.
REQ-006 Port q_data_i  input  NUM_MASTERS*REQ_WIDTH  head entry of queue i at bits [(i+1)*REQ_WIDTH-1 : i*REQ_WIDTH].
REQ-007 Port q_pop_o  output  NUM_MASTERS  one-hot pop strobe to queue i.
REQ-008 Port req_valid_o  output  1  granted request held for downstream.
REQ-009 Port req_ready_i  input  1  downstream accepts request.
REQ-010 Port req_data_o  output  REQ_WIDTH  granted request, registered.
REQ-011 Port req_src_o  output  MASTER_ID_WIDTH  index of the granting master, registered.

Function
REQ-012 FSM states: IDLE (output register empty, req_valid_o=0) and HOLD (req_valid_o=1); state is encoded by req_valid_o.
REQ-013 A load is enabled when the FSM is in IDLE, or when it is in HOLD with req_ready_i=1 in the same cycle.
REQ-014 On a load-enabled cycle with at least one queue having q_empty_i=0, the grant g is the first non-empty index scanned from rr_ptr upward, wrapping from NUM_MASTERS-1 to 0.
REQ-015 q_pop_o is combinational: q_pop_o[g]=1 in the grant cycle only, all other bits 0; at most one bit is ever set.
REQ-016 In the grant cycle, the next edge loads q_data_i slice g into req_data_o and g into req_src_o, sets req_valid_o=1 and sets rr_ptr to (g+1) mod NUM_MASTERS.
REQ-017 Latency: from a queue going non-empty while the FSM is in IDLE, q_pop_o and the grant occur in the same cycle, and req_valid_o rises on the next cycle.
REQ-018 In HOLD with req_ready_i=0: req_data_o, req_src_o and req_valid_o stay stable, and q_pop_o=0.
REQ-019 In HOLD with req_ready_i=1 and a candidate present, a back-to-back reload occurs, giving one request per cycle sustained.
REQ-020 In HOLD with req_ready_i=1 and all queues empty, req_valid_o=0 on the next cycle (return to IDLE); req_data_o and req_src_o keep their last values.
REQ-021 q_pop_o is never asserted for a queue whose q_empty_i=1.
REQ-022 Fairness: with all queues continuously non-empty, grants rotate strictly: rr_ptr, rr_ptr+1, ... mod NUM_MASTERS.
REQ-023 req_ready_i is ignored in IDLE.
REQ-024 Downstream handshake is AXI-style: once req_valid_o is raised it does not drop until accepted.

Reset
REQ-025 While resetn=0 at a clock edge: req_valid_o=0, req_data_o=0, req_src_o=0, rr_ptr=0, FSM in IDLE.
REQ-026 While resetn=0, q_pop_o=0 regardless of q_empty_i.
REQ-027 Reset asserted in HOLD discards the held request; it is not re-queued.

Structure
REQ-028 NUM_MASTERS, MASTER_ID_WIDTH (= $clog2(NUM_MASTERS), minimum 1) and AR_Q_DATA_WIDTH are defined in param_pkg.
REQ-029 The combinational rotate-and-priority-select is a sub-module rr_pick, with inputs request vector and pointer and outputs grant_valid and grant index.
REQ-030 The block connects directly to the empty_o/data_o/pop_i ports of NUM_MASTERS AR queue instances.

Verification
REQ-031 Reset, all queues empty, 10 cycles -> req_valid_o=0 and q_pop_o=0 throughout.
REQ-032 Only queue 2 non-empty with head 0xABC, from IDLE -> q_pop_o=4'b0100 in cycle T; at T+1, req_valid_o=1, req_data_o=0xABC, req_src_o=2.
REQ-033 All 4 queues non-empty, req_ready_i tied to 1 -> req_src_o sequence 0,1,2,3,0,1 with one grant per cycle and no gaps.
REQ-034 Request held, req_ready_i=0 for 5 cycles while queue 1 fills -> data stable, no pops; on ready=1, same-cycle pop of queue 1.
REQ-035 rr_ptr=3 with queues 0 and 3 non-empty -> grant 3 first, then 0 (wrap-around).
REQ-036 resetn=0 during HOLD, then released -> req_valid_o=0, rr_ptr=0, and the next grant starts scanning from queue 0.
